// File: rtl/ssd1306_pkg.sv
`default_nettype none
// ============================================================================
// ssd1306_pkg : shared state encoding, init command list and sizing helpers
// Rev 1.0
// ============================================================================
package ssd1306_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_PWR_WAIT  = 4'd0;
  localparam state_t ST_RST_LOW   = 4'd1;
  localparam state_t ST_RST_REL   = 4'd2;
  localparam state_t ST_LOAD_INIT = 4'd3;
  localparam state_t ST_SEND      = 4'd4;
  localparam state_t ST_NEXT      = 4'd5;
  localparam state_t ST_IDLE      = 4'd6;
  localparam state_t ST_LOAD_CMD  = 4'd7;
  localparam state_t ST_FETCH     = 4'd8;
  localparam state_t ST_LOAD_PIX  = 4'd9;

  // Tells NEXT which kind of byte just went out.
  typedef enum logic [1:0] {MODE_INIT, MODE_CMD, MODE_PIX} mode_t;

  localparam int INIT_LEN = 23;

  function automatic logic [7:0] init_byte(input logic [4:0] idx, input int height);
    case (idx)
      5'd0:    init_byte = 8'hAE;
      5'd1:    init_byte = 8'h81;
      5'd2:    init_byte = 8'h7F;
      5'd3:    init_byte = 8'hA6;
      5'd4:    init_byte = 8'h20;
      5'd5:    init_byte = 8'h00;
      5'd6:    init_byte = 8'hC8;
      5'd7:    init_byte = 8'h40;
      5'd8:    init_byte = 8'hA1;
      5'd9:    init_byte = 8'hA8;
      5'd10:   init_byte = 8'(height - 1);
      5'd11:   init_byte = 8'hD3;
      5'd12:   init_byte = 8'h00;
      5'd13:   init_byte = 8'hD5;
      5'd14:   init_byte = 8'h80;
      5'd15:   init_byte = 8'hD9;
      5'd16:   init_byte = 8'h22;
      5'd17:   init_byte = 8'hDB;
      5'd18:   init_byte = 8'h20;
      5'd19:   init_byte = 8'h8D;
      5'd20:   init_byte = 8'h14;
      5'd21:   init_byte = 8'hA4;
      default: init_byte = 8'hAF;
    endcase
  endfunction

  function automatic int frame_bytes(input int w, input int h);
    return (w * h) / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ssd1306_spi_shift.sv
`default_nettype none
// ============================================================================
// ssd1306_spi_shift : MSB-first byte shifter, SCLK half-period = CLK_DIV clocks
// Rev 1.0
// ============================================================================
module ssd1306_spi_shift #(
  parameter int CLK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  input  logic       dc_i,
  output logic       sclk_o,
  output logic       sdin_o,
  output logic       dc_o,
  output logic       done_o
);

  localparam int                DIV_W    = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [2:0]       bit_q;
  logic [7:0]       sr_q;
  logic             active_q;
  logic             sclk_q;
  logic             sdin_q;
  logic             dc_q;
  logic             phase_end;

  assign phase_end = active_q && (div_q == DIV_LAST);
  // Last cycle of the final high phase, so the FSM leaves SEND on time.
  assign done_o    = phase_end && sclk_q && (bit_q == 3'd7);
  assign sclk_o    = sclk_q;
  assign sdin_o    = sdin_q;
  assign dc_o      = dc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      bit_q    <= '0;
      sr_q     <= '0;
      active_q <= 1'b0;
      sclk_q   <= 1'b1;
      sdin_q   <= 1'b0;
      dc_q     <= 1'b1;
    end else if (start_i) begin
      div_q    <= '0;
      bit_q    <= '0;
      sr_q     <= byte_i;
      active_q <= 1'b1;
      sclk_q   <= 1'b0;
      sdin_q   <= byte_i[7];
      dc_q     <= dc_i;
    end else if (active_q) begin
      if (!phase_end) begin
        div_q <= div_q + 1'b1;
      end else begin
        div_q <= '0;
        if (!sclk_q) begin
          sclk_q <= 1'b1;
        end else if (bit_q == 3'd7) begin
          active_q <= 1'b0;
        end else begin
          // sdin only moves together with the falling SCLK edge.
          sclk_q <= 1'b0;
          bit_q  <= bit_q + 3'd1;
          sr_q   <= {sr_q[6:0], 1'b0};
          sdin_q <= sr_q[6];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ssd1306_spi_ctrl.sv
`default_nettype none
// ============================================================================
// ssd1306_spi_ctrl : SSD1306 power-up, init list, host commands, frame streaming
// Rev 1.0
// ============================================================================
module ssd1306_spi_ctrl
  import ssd1306_pkg::*;
#(
  parameter int WIDTH        = 128,
  parameter int HEIGHT       = 64,
  parameter int CLK_DIV      = 1,
  parameter int STARTUP_WAIT = 10_000_000,
  parameter int AUTO_REFRESH = 0,
  parameter int ADDR_W       = $clog2(WIDTH * HEIGHT / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              cmd_valid,
  input  logic [7:0]        cmd_data,
  output logic              cmd_ready,
  output logic [ADDR_W-1:0] pixel_addr,
  input  logic [7:0]        pixel_data,
  output logic              busy,
  output logic              frame_done,
  output logic              io_sclk,
  output logic              io_sdin,
  output logic              io_cs,
  output logic              io_dc,
  output logic              io_reset
);

  localparam int                NBYTES    = frame_bytes(WIDTH, HEIGHT);
  localparam int                CNT_W     = $clog2(STARTUP_WAIT) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STARTUP_WAIT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NBYTES - 1);

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        cmd_q, cmd_d;
  logic              frame_done_q, frame_done_d;
  logic              cs_q, reset_q;

  logic              shift_start, shift_dc, shift_done;
  logic [7:0]        shift_byte;

  assign shift_start = state_q inside {ST_LOAD_INIT, ST_LOAD_CMD, ST_LOAD_PIX};

  always_comb begin
    shift_byte = cmd_q;
    shift_dc   = 1'b0;
    if (state_q == ST_LOAD_INIT) begin
      shift_byte = init_byte(idx_q, HEIGHT);
    end else if (state_q == ST_LOAD_PIX) begin
      shift_byte = pixel_data;
      shift_dc   = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    case (state_q)
      ST_PWR_WAIT, ST_RST_LOW, ST_RST_REL: begin
        mode_d = MODE_INIT;
        idx_d  = '0;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = (state_q == ST_PWR_WAIT) ? ST_RST_LOW :
                    (state_q == ST_RST_LOW)  ? ST_RST_REL : ST_LOAD_INIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LOAD_INIT, ST_LOAD_CMD, ST_LOAD_PIX: state_d = ST_SEND;
      ST_SEND: if (shift_done) state_d = ST_NEXT;
      ST_NEXT: begin
        case (mode_q)
          MODE_INIT: begin
            if (idx_q == 5'(INIT_LEN - 1)) begin
              state_d = ST_IDLE;
            end else begin
              idx_d   = idx_q + 5'd1;
              state_d = ST_LOAD_INIT;
            end
          end
          MODE_PIX: begin
            addr_d  = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
            state_d = (addr_q == ADDR_LAST) ? ST_IDLE : ST_FETCH;
          end
          default: state_d = ST_IDLE;
        endcase
      end
      ST_IDLE: begin
        // Host commands win so they can slip in between auto-refresh frames.
        if (cmd_valid) begin
          cmd_d   = cmd_data;
          mode_d  = MODE_CMD;
          state_d = ST_LOAD_CMD;
        end else if (frame_start || (AUTO_REFRESH != 0)) begin
          addr_d  = '0;
          mode_d  = MODE_PIX;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_LOAD_PIX;
      default:  state_d = ST_PWR_WAIT;
    endcase
    frame_done_d = (state_d == ST_NEXT) && (mode_q == MODE_PIX) && (addr_q == ADDR_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_PWR_WAIT;
      mode_q       <= MODE_INIT;
      cnt_q        <= '0;
      idx_q        <= '0;
      addr_q       <= '0;
      cmd_q        <= '0;
      frame_done_q <= 1'b0;
      cs_q         <= 1'b1;
      reset_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      cmd_q        <= cmd_d;
      frame_done_q <= frame_done_d;
      // Chip select spans load, fetch and shift so it pulses high only in NEXT.
      cs_q         <= !(state_d inside {ST_LOAD_INIT, ST_LOAD_CMD, ST_FETCH, ST_LOAD_PIX, ST_SEND});
      reset_q      <= (state_d != ST_RST_LOW);
    end
  end

  ssd1306_spi_shift #(
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .start_i (shift_start),
    .byte_i  (shift_byte),
    .dc_i    (shift_dc),
    .sclk_o  (io_sclk),
    .sdin_o  (io_sdin),
    .dc_o    (io_dc),
    .done_o  (shift_done)
  );

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign pixel_addr = addr_q;
  assign frame_done = frame_done_q;
  assign io_cs      = cs_q;
  assign io_reset   = reset_q;

endmodule
`default_nettype wire

// File: tb/tb_ssd1306_spi_ctrl.sv
`default_nettype none
// ============================================================================
// tb_ssd1306_spi_ctrl : scoreboard bench, two configurations decoded off the SPI pins
// Rev 1.0
// ============================================================================
module tb_ssd1306_spi_ctrl;

  localparam logic [7:0] INIT_TBL [23] = '{
    8'hAE, 8'h81, 8'h7F, 8'hA6, 8'h20, 8'h00, 8'hC8, 8'h40, 8'hA1, 8'hA8, 8'h00, 8'hD3,
    8'h00, 8'hD5, 8'h80, 8'hD9, 8'h22, 8'hDB, 8'h20, 8'h8D, 8'h14, 8'hA4, 8'hAF};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 16x32, CLK_DIV=1, manual frames.
  logic       rst_a = 1'b1, fs_a = 1'b0, cv_a = 1'b0;
  logic [7:0] cd_a = 8'h00, pd_a;
  logic [5:0] pa_a;
  logic       rdy_a, busy_a, fd_a, sclk_a, sdin_a, cs_a, dc_a, rs_a;
  // Instance B: 8x16, CLK_DIV=3, auto-refresh.
  logic       rst_b = 1'b1, fs_b = 1'b0, cv_b = 1'b0;
  logic [7:0] cd_b = 8'h00, pd_b;
  logic [3:0] pa_b;
  logic       rdy_b, busy_b, fd_b, sclk_b, sdin_b, cs_b, dc_b, rs_b;

  ssd1306_spi_ctrl #(.WIDTH(16), .HEIGHT(32), .CLK_DIV(1), .STARTUP_WAIT(4), .AUTO_REFRESH(0)) u_dut_a (
    .clk(clk), .rst(rst_a), .frame_start(fs_a), .cmd_valid(cv_a), .cmd_data(cd_a),
    .cmd_ready(rdy_a), .pixel_addr(pa_a), .pixel_data(pd_a), .busy(busy_a), .frame_done(fd_a),
    .io_sclk(sclk_a), .io_sdin(sdin_a), .io_cs(cs_a), .io_dc(dc_a), .io_reset(rs_a));

  ssd1306_spi_ctrl #(.WIDTH(8), .HEIGHT(16), .CLK_DIV(3), .STARTUP_WAIT(4), .AUTO_REFRESH(1)) u_dut_b (
    .clk(clk), .rst(rst_b), .frame_start(fs_b), .cmd_valid(cv_b), .cmd_data(cd_b),
    .cmd_ready(rdy_b), .pixel_addr(pa_b), .pixel_data(pd_b), .busy(busy_b), .frame_done(fd_b),
    .io_sclk(sclk_b), .io_sdin(sdin_b), .io_cs(cs_b), .io_dc(dc_b), .io_reset(rs_b));

  // Framebuffer RAM with RAM[i] = i and one cycle of read latency.
  always @(posedge clk) begin
    pd_a <= {2'b00, pa_a};
    pd_b <= {4'b0000, pa_b};
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] init_ref(input int i, input int h);
    if (i == 10) return 8'(h - 1);
    return INIT_TBL[i];
  endfunction

  logic [8:0] qa[$];
  logic [8:0] qb[$];

  int fdc_a = 0, fdc_b = 0;
  always @(negedge clk) begin
    if (fd_a) fdc_a <= fdc_a + 1;
    if (fd_b) fdc_b <= fdc_b + 1;
  end

  // SPI monitor state, index 0 = A, 1 = B.
  int         nbit[2], run[2], nbytes[2];
  logic       ps[2], pdn[2];
  logic [7:0] sh[2], last_byte[2];

  task automatic mon(input int k, input logic rs, input logic s, input logic d,
                     input logic c, input logic dcv);
    int cd;
    cd = (k == 0) ? 1 : 3;
    if (rs) begin
      nbit[k] = 0; run[k] = 0; ps[k] = s; pdn[k] = d;
      return;
    end
    if (!c && (d !== pdn[k])) check_val("sdin_change_while_sclk_high", 32'(s), 0);
    if (s == ps[k]) begin
      run[k]++;
    end else begin
      if (!ps[k]) check_val("sclk_low_len", run[k], cd);
      else if (nbit[k] != 0) check_val("sclk_high_len", run[k], cd);
      run[k] = 1;
      if (s && !c) begin
        sh[k] = {sh[k][6:0], d};
        nbit[k]++;
        if (nbit[k] == 8) begin
          nbit[k] = 0;
          nbytes[k]++;
          last_byte[k] = sh[k];
          if (k == 0) begin
            if (qa.size() == 0) check_val("spi_extra_byte_a", qa.size(), 1);
            else check_val("spi_byte_a", {23'd0, dcv, sh[k]}, {23'd0, qa.pop_front()});
          end else begin
            if (qb.size() == 0) check_val("spi_extra_byte_b", qb.size(), 1);
            else check_val("spi_byte_b", {23'd0, dcv, sh[k]}, {23'd0, qb.pop_front()});
          end
        end
      end
    end
    ps[k] = s;
    pdn[k] = d;
  endtask

  always @(negedge clk) begin
    mon(0, rst_a, sclk_a, sdin_a, cs_a, dc_a);
    mon(1, rst_b, sclk_b, sdin_b, cs_b, dc_b);
  end

  task automatic power_up_a();
    int k, nb0;
    rst_a = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 23; i++) qa.push_back({1'b0, init_ref(i, 32)});
    check_val("reset_pins_a", {28'd0, busy_a, rdy_a, cs_a, sclk_a}, 32'hB);
    nb0 = nbytes[0];
    rst_a = 1'b0;
    k = 0;
    while (k < 2000 && !rdy_a) begin
      @(negedge clk);
      k++;
      if (k <= 12) check_val("io_reset_seq", 32'(rs_a), (k >= 4 && k <= 7) ? 0 : 1);
    end
    check_val("init_done_cycles", 32'(k >= 425 && k <= 427), 1);
    check_val("init_queue_left", qa.size(), 0);
    check_val("init_byte_count", nbytes[0] - nb0, 23);
    check_val("last_byte_before_ready", 32'(last_byte[0]), 32'hAF);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 2; i++) begin
      nbit[i] = 0; run[i] = 0; nbytes[i] = 0; ps[i] = 1'b1; pdn[i] = 1'b0;
      sh[i] = 8'h00; last_byte[i] = 8'h00;
    end

    power_up_a();

    // Full frame on A.
    check_val("idle_busy_a", 32'(busy_a), 0);
    for (int i = 0; i < 64; i++) qa.push_back({1'b1, 8'(i)});
    fs_a = 1'b1;
    @(negedge clk);
    fs_a = 1'b0;
    k = 1;
    while (k < 3000 && !fd_a) begin @(negedge clk); k++; end
    check_val("frame_done_cycle", k, 64 * 19);
    @(negedge clk);
    check_val("busy_after_frame", 32'(busy_a), 0);
    check_val("addr_wrapped", 32'(pa_a), 0);
    check_val("frame_queue_left", qa.size(), 0);

    // Command and frame_start together: only the command goes out.
    qa.push_back({1'b0, 8'hA7});
    cv_a = 1'b1; cd_a = 8'hA7; fs_a = 1'b1;
    @(negedge clk);
    cv_a = 1'b0; fs_a = 1'b0;
    check_val("cmd_accepted_busy", 32'(busy_a), 1);
    repeat (3) @(negedge clk);
    fs_a = 1'b1;
    @(negedge clk);
    fs_a = 1'b0;
    repeat (80) @(negedge clk);
    check_val("cmd_queue_left", qa.size(), 0);
    check_val("idle_after_cmd", 32'(busy_a), 0);
    check_val("frame_done_count_a", fdc_a, 1);

    // Reset mid-byte in a frame.
    for (int i = 0; i < 64; i++) qa.push_back({1'b1, 8'(i)});
    fs_a = 1'b1;
    @(negedge clk);
    fs_a = 1'b0;
    repeat (30) @(negedge clk);
    rst_a = 1'b1;
    #1;
    check_val("rst_sclk", 32'(sclk_a), 1);
    check_val("rst_sdin", 32'(sdin_a), 0);
    check_val("rst_cs", 32'(cs_a), 1);
    check_val("rst_dc", 32'(dc_a), 1);
    check_val("rst_reset_pin", 32'(rs_a), 1);
    check_val("rst_busy", 32'(busy_a), 1);
    check_val("rst_cmd_ready", 32'(rdy_a), 0);
    check_val("rst_frame_done", 32'(fd_a), 0);
    check_val("rst_pixel_addr", 32'(pa_a), 0);
    qa.delete();
    power_up_a();
    rst_a = 1'b1;

    // Instance B: init, auto frame, held command slips in, frame restarts at 0.
    for (int i = 0; i < 23; i++) qb.push_back({1'b0, init_ref(i, 16)});
    for (int i = 0; i < 16; i++) qb.push_back({1'b1, 8'(i)});
    rst_b = 1'b0;
    k = 0;
    while (k < 3000 && !rdy_b) begin @(negedge clk); k++; end
    check_val("b_init_timeout", 32'(k < 3000), 1);
    @(negedge clk);
    check_val("b_auto_frame_started", 32'(busy_b), 1);
    qb.push_back({1'b0, 8'hAE});
    for (int i = 0; i < 16; i++) qb.push_back({1'b1, 8'(i)});
    cv_b = 1'b1; cd_b = 8'hAE;
    k = 0;
    while (k < 3000 && !rdy_b) begin @(negedge clk); k++; end
    check_val("b_cmd_wait_timeout", 32'(k < 3000), 1);
    check_val("b_frames_before_cmd", fdc_b, 1);
    @(negedge clk);
    cv_b = 1'b0;
    check_val("b_cmd_taken", 32'(rdy_b), 0);
    k = 0;
    while (k < 3000 && fdc_b < 2) begin @(negedge clk); k++; end
    check_val("b_second_frame_timeout", 32'(k < 3000), 1);
    check_val("b_queue_left", qb.size(), 0);
    rst_b = 1'b1;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
